// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit CPU sequencer: opcodes, ALU selects,
// FSM state encoding and instruction field slices.
// Latency: n/a (package). Backpressure: n/a.
package cpu_pkg;

   localparam logic [3:0] OP_NOOP  = 4'h0;
   localparam logic [3:0] OP_STORE = 4'h1;
   localparam logic [3:0] OP_LOAD  = 4'h2;
   localparam logic [3:0] OP_ADD   = 4'h3;
   localparam logic [3:0] OP_SUB   = 4'h4;
   localparam logic [3:0] OP_HALT  = 4'h5;

   localparam logic [2:0] ALU_PASS_A = 3'd0;
   localparam logic [2:0] ALU_ADD    = 3'd1;
   localparam logic [2:0] ALU_SUB    = 3'd2;

   // Encoding order is visible on the OutState debug port.
   typedef enum logic [3:0] {
      INIT   = 4'd0,
      FETCH  = 4'd1,
      DECODE = 4'd2,
      NOOP   = 4'd3,
      LOAD_A = 4'd4,
      LOAD_B = 4'd5,
      STORE  = 4'd6,
      ADD    = 4'd7,
      SUB    = 4'd8,
      HALT   = 4'd9
   } state_t;

   function automatic logic [3:0] f_opcode(input logic [15:0] ir);
      return ir[15:12];
   endfunction

   // Ra lives in [11:8] for both STORE and ADD/SUB.
   function automatic logic [3:0] f_ra(input logic [15:0] ir);
      return ir[11:8];
   endfunction

   function automatic logic [3:0] f_rb(input logic [15:0] ir);
      return ir[7:4];
   endfunction

   function automatic logic [3:0] f_rw(input logic [15:0] ir);
      return ir[3:0];
   endfunction

   function automatic logic [7:0] f_load_addr(input logic [15:0] ir);
      return ir[11:4];
   endfunction

   function automatic logic [7:0] f_store_addr(input logic [15:0] ir);
      return ir[7:0];
   endfunction

endpackage

// File: rtl/pc_counter.sv
// Program counter: PC_W-bit register, synchronous increment, natural wrap.
// Latency: count updates on the rising edge after inc is sampled high.
// Backpressure: none; holds its value whenever inc is low.
//  Ports: clk, rst (async, active-high, clears to 0), inc (increment enable),
//         count (current PC).
module pc_counter #(
   parameter int PC_W = 7
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            inc,
   output logic [PC_W-1:0] count
);

   // All-ones + 1 wraps to 0 by modular arithmetic.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (inc) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/cpu_controller.sv
// Multi-cycle sequencer: fetch from sync-read ROM, decode, drive datapath controls.
// Latency: NOOP/STORE/ADD/SUB 3 cycles, LOAD 4 cycles, HALT terminal until Reset.
// Backpressure: none; ROM data is assumed valid the cycle after a FETCH.
//  Ports: Clock, Reset (async active-high); I_Data/I_Addr/I_Rd to instruction ROM;
//         D_Addr/D_Wr to data memory; RF_s, RF_W_Addr, RF_W_en, RF_Ra_Addr,
//         RF_Rb_Addr, ALU_s0 to datapath; OutState/PC_Out/IR_Out for debug.
module cpu_controller
   import cpu_pkg::*;
#(
   parameter int PC_W = 7
) (
   input  logic            Clock,
   input  logic            Reset,
   input  logic [15:0]     I_Data,
   output logic [PC_W-1:0] I_Addr,
   output logic            I_Rd,
   output logic [7:0]      D_Addr,
   output logic            D_Wr,
   output logic            RF_s,
   output logic [3:0]      RF_W_Addr,
   output logic            RF_W_en,
   output logic [3:0]      RF_Ra_Addr,
   output logic [3:0]      RF_Rb_Addr,
   output logic [2:0]      ALU_s0,
   output logic [3:0]      OutState,
   output logic [PC_W-1:0] PC_Out,
   output logic [15:0]     IR_Out
);

   state_t          state;
   state_t          next_state;
   logic [15:0]     ir;
   logic [PC_W-1:0] pc;
   logic            pc_inc;

   // PC advances on the edge that ends FETCH; HALT never reaches FETCH so PC freezes.
   assign pc_inc = (state == FETCH);

   pc_counter #(
      .PC_W (PC_W)
   ) u_pc (
      .clk   (Clock),
      .rst   (Reset),
      .inc   (pc_inc),
      .count (pc)
   );

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state <= INIT;
      end else begin
         state <= next_state;
      end
   end

   // ROM word is on I_Data during DECODE; capture it for the execute states.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         ir <= '0;
      end else if (state == DECODE) begin
         ir <= I_Data;
      end
   end

   // Next state. DECODE branches on I_Data since IR is only loaded at its end.
   always_comb begin
      next_state = state;
      unique case (state)
         INIT:   next_state = FETCH;
         FETCH:  next_state = DECODE;
         DECODE: begin
            case (f_opcode(I_Data))
               OP_STORE: next_state = STORE;
               OP_LOAD:  next_state = LOAD_A;
               OP_ADD:   next_state = ADD;
               OP_SUB:   next_state = SUB;
               OP_HALT:  next_state = HALT;
               default:  next_state = NOOP;
            endcase
         end
         LOAD_A: next_state = LOAD_B;
         NOOP, STORE, LOAD_B, ADD, SUB: next_state = FETCH;
         HALT:   next_state = HALT;
         default: next_state = INIT;
      endcase
   end

   // Moore outputs from state + IR only, so an async reset clears enables immediately.
   // Anything not used by the current state stays at 0.
   always_comb begin
      I_Rd       = 1'b0;
      D_Addr     = '0;
      D_Wr       = 1'b0;
      RF_s       = 1'b0;
      RF_W_Addr  = '0;
      RF_W_en    = 1'b0;
      RF_Ra_Addr = '0;
      RF_Rb_Addr = '0;
      ALU_s0     = ALU_PASS_A;
      unique case (state)
         FETCH: I_Rd = 1'b1;
         STORE: begin
            D_Addr     = f_store_addr(ir);
            RF_Ra_Addr = f_ra(ir);
            D_Wr       = 1'b1;
         end
         LOAD_A: begin
            // Data memory read latency: address presented, write held off one cycle.
            D_Addr    = f_load_addr(ir);
            RF_s      = 1'b1;
            RF_W_Addr = f_rw(ir);
         end
         LOAD_B: begin
            D_Addr    = f_load_addr(ir);
            RF_s      = 1'b1;
            RF_W_Addr = f_rw(ir);
            RF_W_en   = 1'b1;
         end
         ADD, SUB: begin
            RF_Ra_Addr = f_ra(ir);
            RF_Rb_Addr = f_rb(ir);
            RF_W_Addr  = f_rw(ir);
            RF_W_en    = 1'b1;
            ALU_s0     = (state == ADD) ? ALU_ADD : ALU_SUB;
         end
         default: ;
      endcase
   end

   assign I_Addr   = pc;
   assign OutState = state;
   assign PC_Out   = pc;
   assign IR_Out   = ir;

endmodule
